store_rmw_ctrl: RTL

//  Sequencer for CPU store instructions (sw/sh/sb) against word-wide memory.
//  Sub-word stores use read-modify-write: read the target word into an internal
//  MDR, merge the low bits of B, then write the word back. The merge is built
//  in: halfword {MDR[31:16],B[15:0]}, byte {MDR[31:8],B[7:0]}.

---
 rtl/store_rmw_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/store_rmw_ctrl.sv
// Store sequencer for sw/sh/sb against word-wide memory.
// Sub-word stores read the word, merge the low bits of B, and write it back.
module store_rmw_ctrl #(
    parameter int MEM_RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] data_b,
    output logic        busy,
    output logic        done,
    output logic        misalign,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    localparam int CW = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;
    localparam logic [CW-1:0] LAST = CW'(MEM_RD_LAT - 1);

    state_t      state, state_n;
    logic [31:0] addr_q, b_q, mdr_q;
    logic [1:0]  size_q;
    logic        mis_q;
    logic [CW-1:0] cnt_q;

    logic accept, is_half, is_byte, is_sub, mis;
    logic [31:0] merged;

    assign accept  = (state == S_IDLE) && start;
    assign is_half = (size == 2'b01);
    assign is_byte = (size == 2'b10);
    assign is_sub  = is_half || is_byte;
    // Size 11 falls into the word case for both alignment and merge.
    assign mis     = is_half ? addr[0] : (!is_byte && (addr[1:0] != 2'b00));

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    if (mis)         state_n = S_DONE;
                    else if (is_sub) state_n = S_READ;
                    else             state_n = S_WRITE;
                end
            end
            S_READ:  state_n = S_WAIT;
            S_WAIT:  if (cnt_q == LAST) state_n = S_WRITE;
            S_WRITE: state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
            b_q    <= '0;
            mdr_q  <= '0;
            size_q <= '0;
            mis_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (accept) begin
                addr_q <= addr;
                b_q    <= data_b;
                size_q <= size;
                mis_q  <= mis;
            end
            if (state == S_READ)      cnt_q <= '0;
            else if (state == S_WAIT) cnt_q <= cnt_q + 1'b1;
            if (state == S_WAIT && cnt_q == LAST) mdr_q <= mem_rdata;
        end
    end

    // Sub-word data always lands in the low lane regardless of addr[1:0].
    always_comb begin
        unique case (size_q)
            2'b01:   merged = {mdr_q[31:16], b_q[15:0]};
            2'b10:   merged = {mdr_q[31:8], b_q[7:0]};
            default: merged = b_q;
        endcase
    end

    always_comb begin
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        misalign  = (state == S_DONE) && mis_q;
        mem_rd    = (state == S_READ);
        mem_wr    = (state == S_WRITE);
        mem_addr  = {addr_q[31:2], 2'b00};
        mem_wdata = (state == S_WRITE) ? merged : 32'h0;
    end

endmodule
